pc_sequencer: RTL and testbench

- Fetch-stage controller that owns the PC register and decides the next fetch address every cycle.
- Selects among sequential PC+4, the branch/jump target produced by the next-PC logic in D, exception entry, ERET return and stall hold.
- Latches a redirect that arrives during a stall.
- Flags misaligned or out-of-range fetch addresses.
- Sits between the hazard unit, the D-stage next-PC logic, CP0 and instruction memory.

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_addr_check.sv | 18 +
 rtl/pc_sequencer.sv | 86 ++++++++
 tb/tb_pc_sequencer.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU constants for the fetch stage: reset/exception addresses,
// legal instruction-memory window and the PC sequencer state encoding.
package cpu_consts;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_PC    = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] IMEM_TOP  = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer and its neighbours
// (hazard unit, D-stage next-PC logic, CP0, instruction memory).
interface pc_sequencer_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        fetch_valid;
  logic        flush_fd;
  logic        adel_f;
  logic        redirect_pending;

  modport master (
    output stall, redirect_valid, redirect_target, exc_req, eret_req, epc,
    input  pc_f, pc_plus4_f, fetch_valid, flush_fd, adel_f, redirect_pending
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, exc_req, eret_req, epc,
    output pc_f, pc_plus4_f, fetch_valid, flush_fd, adel_f, redirect_pending
  );

endinterface

// File: rtl/pc_addr_check.sv
// Fetch address error detection: word alignment plus the legal
// instruction-memory window, only meaningful while a real fetch is in flight.
module pc_addr_check
  import cpu_consts::*;
(
  input  logic [31:0] pc,
  input  logic        fetch_valid,
  output logic        adel
);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = (pc[1:0] != 2'b00);
  assign out_of_range = (pc < IMEM_BASE) || (pc > IMEM_TOP);
  assign adel         = fetch_valid && (misaligned || out_of_range);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC and picks the next fetch address from
// exception entry, ERET return, stall hold, latched/live redirect or PC+4.
module pc_sequencer
  import cpu_consts::*;
(
  input  logic           clk,
  input  logic           reset_n,
  pc_sequencer_if.slave  bus
);

  seq_state_t  state;
  seq_state_t  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pend_target;
  logic [31:0] pend_target_next;
  logic        flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_target <= 32'h0000_0000;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_target <= pend_target_next;
    end
  end

  // Priority: exception > ERET > stall hold > pending release > redirect > PC+4.
  // A redirect never flushes F/D, since the instruction at pc_f is its delay slot.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    pend_target_next = pend_target;
    flush            = 1'b0;

    case (state)
      BOOT: begin
        state_next = RUN;
      end
      default: begin
        if (bus.exc_req) begin
          pc_next          = EXC_PC;
          pend_target_next = 32'h0000_0000;
          flush            = 1'b1;
          state_next       = RUN;
        end else if (bus.eret_req) begin
          pc_next          = bus.epc;
          pend_target_next = 32'h0000_0000;
          flush            = 1'b1;
          state_next       = RUN;
        end else if (bus.stall) begin
          if (bus.redirect_valid) begin
            pend_target_next = bus.redirect_target;
          end
          state_next = (bus.redirect_valid || state == PEND) ? PEND : RUN;
        end else if (state == PEND) begin
          pc_next          = bus.redirect_valid ? bus.redirect_target : pend_target;
          pend_target_next = 32'h0000_0000;
          state_next       = RUN;
        end else if (bus.redirect_valid) begin
          pc_next    = bus.redirect_target;
          state_next = RUN;
        end else begin
          pc_next    = pc + 32'd4;
          state_next = RUN;
        end
      end
    endcase
  end

  assign bus.pc_f             = pc;
  assign bus.pc_plus4_f       = pc + 32'd4;
  assign bus.fetch_valid      = (state != BOOT);
  assign bus.redirect_pending = (state == PEND);
  assign bus.flush_fd         = flush;

  pc_addr_check u_addr_check (
    .pc          (pc),
    .fetch_valid (bus.fetch_valid),
    .adel        (bus.adel_f)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random
// traffic, all compared against a behavioural fetch-address model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: where fetch is, whether the first post-reset cycle is
  // still pending, and whether a redirect is parked behind a stall.
  logic [31:0] m_pc;
  bit          m_booting;
  bit          m_parked;
  logic [31:0] m_parked_target;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc            = 32'h3000;
    m_booting       = 1'b1;
    m_parked        = 1'b0;
    m_parked_target = 32'h0;
  endtask

  // Called at a falling edge: drive inputs, check outputs, advance the model
  // to what the next rising edge should produce, then move to the next falling edge.
  task automatic step(input logic s, input logic rv, input logic [31:0] rt,
                      input logic e, input logic er, input logic [31:0] ep);
    bit fv;
    bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = rt;
    bus.exc_req = e; bus.eret_req = er; bus.epc = ep;
    #1;
    fv = !m_booting;
    check("pc_f", bus.pc_f, m_pc);
    check("pc_plus4_f", bus.pc_plus4_f, m_pc + 32'd4);
    check("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, fv});
    check("flush_fd", {31'b0, bus.flush_fd}, {31'b0, fv && (e || er)});
    check("redirect_pending", {31'b0, bus.redirect_pending}, {31'b0, m_parked});
    check("adel_f", {31'b0, bus.adel_f}, {31'b0, fv && addr_bad(m_pc)});
    if (m_booting) m_booting = 1'b0;
    else if (e) begin m_pc = 32'h4180; m_parked = 1'b0; end
    else if (er) begin m_pc = ep; m_parked = 1'b0; end
    else if (s) begin
      if (rv) begin m_parked = 1'b1; m_parked_target = rt; end
    end
    else if (m_parked) begin m_pc = rv ? rt : m_parked_target; m_parked = 1'b0; end
    else if (rv) m_pc = rt;
    else m_pc = m_pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_pc_f", bus.pc_f, 32'h3000);
    check("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
    check("rst_flush_fd", {31'b0, bus.flush_fd}, 32'h0);
    check("rst_redirect_pending", {31'b0, bus.redirect_pending}, 32'h0);
  endtask

  logic [31:0] rnd_addr;

  initial begin
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.epc = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;

    // Boot cycle with an exception request that must be ignored.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    repeat (4) idle();
    step(1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0);
    idle();
    // Redirect captured under a three-cycle stall.
    step(1'b1, 1'b1, 32'h3200, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    // Last redirect wins while parked; exception under stall clears the park.
    step(1'b1, 1'b1, 32'h3300, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h3340, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3024);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3024);
    idle();
    // Live redirect outranks the parked target on stall release.
    step(1'b1, 1'b1, 32'h3500, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h3600, 1'b0, 1'b0, 32'h0);
    // Address error boundaries.
    step(1'b0, 1'b1, 32'h3102, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h7000, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h6FF8, 1'b0, 1'b0, 32'h0);
    idle();
    idle();
    step(1'b0, 1'b1, 32'h2FFC, 1'b0, 1'b0, 32'h0);
    // PC+4 wraps at 2^32.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle();
    idle();

    // Asynchronous reset while a redirect is parked.
    step(1'b1, 1'b1, 32'h3700, 1'b0, 1'b0, 32'h0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      rnd_addr = 32'h3000 + ($urandom_range(0, 4095) << 2);
      if ($urandom_range(0, 9) == 0) rnd_addr = $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rnd_addr,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           32'h3000 + ($urandom_range(0, 4095) << 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
